// File: rtl/cbrt_sqrt_ctrl.sv
// Controller and shared add/subtract unit for the y = cbrt(a) + sqrt(b) kernel.
// Accepts operand pairs, starts the kernel, captures the final sum and the start-to-done latency.
module cbrt_sqrt_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] a_bi,
    input  logic [7:0] b_bi,
    output logic [7:0] k_a_bo,
    output logic [7:0] k_b_bo,
    output logic       k_start_o,
    input  logic       k_done_i,
    input  logic       alu_mode_i,
    input  logic [7:0] alu_a_i,
    input  logic [7:0] alu_b_i,
    output logic [7:0] alu_res_o,
    output logic [7:0] y_bo,
    output logic       y_valid_o,
    input  logic       y_ack_i,
    output logic [7:0] cycles_bo,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic [7:0] alu_f(input logic mode, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        if (mode) begin
            res = a + b;
        end else begin
            res = a - b;
        end
        return res;
    endfunction

    function automatic logic [7:0] sat_inc_f(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = v + 8'd1;
        end
        return res;
    endfunction

    state_t     r_state;
    logic [7:0] r_k_a;
    logic [7:0] r_k_b;
    logic       r_k_start;
    logic       r_in_ready;
    logic       r_busy;
    logic [7:0] r_y;
    logic       r_y_valid;
    logic [7:0] r_cycles;
    logic [7:0] r_cnt;

    logic [7:0] w_alu_res;
    logic [7:0] w_cnt_inc;

    // Shared ALU is combinational and live in every state, including reset.
    assign w_alu_res = alu_f(alu_mode_i, alu_a_i, alu_b_i);
    assign w_cnt_inc = sat_inc_f(r_cnt);

    assign alu_res_o  = w_alu_res;
    assign in_ready_o = r_in_ready;
    assign k_a_bo     = r_k_a;
    assign k_b_bo     = r_k_b;
    assign k_start_o  = r_k_start;
    assign y_bo       = r_y;
    assign y_valid_o  = r_y_valid;
    assign cycles_bo  = r_cycles;
    assign busy_o     = r_busy;

    // Control FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_k_a      <= 8'd0;
            r_k_b      <= 8'd0;
            r_k_start  <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_y        <= 8'd0;
            r_y_valid  <= 1'b0;
            r_cycles   <= 8'd0;
            r_cnt      <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_k_a      <= a_bi;
                        r_k_b      <= b_bi;
                        r_cnt      <= 8'd0;
                        r_k_start  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_k_start <= 1'b0;
                    r_cnt     <= 8'd1;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The done cycle itself is included in the reported latency.
                    r_cnt <= w_cnt_inc;
                    if (k_done_i) begin
                        r_y       <= w_alu_res;
                        r_cycles  <= w_cnt_inc;
                        r_y_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (y_ack_i) begin
                        r_y_valid  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_k_start  <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_y_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbrt_sqrt_ctrl.sv
// Directed bench for cbrt_sqrt_ctrl with a stub kernel driving done and the ALU bus.
module tb_cbrt_sqrt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic [7:0] k_a;
    logic [7:0] k_b;
    logic       k_start;
    logic       k_done = 1'b0;
    logic       alu_mode = 1'b0;
    logic [7:0] alu_a = 8'd0;
    logic [7:0] alu_b = 8'd0;
    logic [7:0] alu_res;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ack = 1'b0;
    logic [7:0] cycles;
    logic       busy;

    int checks = 0;
    int failures = 0;

    cbrt_sqrt_ctrl dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_bi(a_in), .b_bi(b_in), .k_a_bo(k_a), .k_b_bo(k_b), .k_start_o(k_start),
        .k_done_i(k_done), .alu_mode_i(alu_mode), .alu_a_i(alu_a), .alu_b_i(alu_b),
        .alu_res_o(alu_res), .y_bo(y), .y_valid_o(y_valid), .y_ack_i(y_ack),
        .cycles_bo(cycles), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_k_a"}, k_a, 8'd0);
        chk({tag, "_k_b"}, k_b, 8'd0);
        chk({tag, "_k_start"}, {7'd0, k_start}, 8'd0);
        chk({tag, "_y"}, y, 8'd0);
        chk({tag, "_y_valid"}, {7'd0, y_valid}, 8'd0);
        chk({tag, "_cycles"}, cycles, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    // Accept a/b, let the stub kernel wait extra WAIT cycles, then raise done with cr+sr on the ALU bus.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cr,
                           input logic [7:0] sr, input int extra_wait,
                           input logic [7:0] exp_y, input logic [7:0] exp_cyc);
        @(negedge clk);
        chk("pre_ready", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_hi", {7'd0, k_start}, 8'd1);
        chk("start_ready", {7'd0, in_ready}, 8'd0);
        chk("start_busy", {7'd0, busy}, 8'd1);
        chk("k_a", k_a, a);
        chk("k_b", k_b, b);
        @(negedge clk);
        chk("start_lo", {7'd0, k_start}, 8'd0);
        repeat (extra_wait) @(negedge clk);
        chk("wait_no_valid", {7'd0, y_valid}, 8'd0);
        k_done = 1'b1; alu_mode = 1'b1; alu_a = cr; alu_b = sr;
        @(negedge clk);
        k_done = 1'b0; alu_mode = 1'b0; alu_a = 8'd0; alu_b = 8'd0;
        chk("y_valid", {7'd0, y_valid}, 8'd1);
        chk("y", y, exp_y);
        chk("cycles", cycles, exp_cyc);
    endtask

    task automatic ack_result();
        @(negedge clk);
        y_ack = 1'b1;
        @(negedge clk);
        y_ack = 1'b0;
        chk("ack_valid", {7'd0, y_valid}, 8'd0);
        chk("ack_ready", {7'd0, in_ready}, 8'd1);
        chk("ack_busy", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b1;

        // Basic sum: 3 + 4, done in the first WAIT cycle -> START + 1 WAIT = 2
        run_txn(8'd27, 8'd16, 8'd3, 8'd4, 0, 8'd7, 8'd2);
        @(negedge clk);
        chk("no_restart", {7'd0, k_start}, 8'd0);
        chk("held_valid", {7'd0, y_valid}, 8'd1);
        ack_result();

        // Directed ALU vectors
        @(negedge clk);
        alu_mode = 1'b1; alu_a = 8'd200; alu_b = 8'd100;
        #1 chk("alu_add_wrap", alu_res, 8'd44);
        alu_mode = 1'b0; alu_a = 8'd3; alu_b = 8'd5;
        #1 chk("alu_sub_wrap", alu_res, 8'hFE);
        alu_mode = 1'b0; alu_a = 8'd9; alu_b = 8'd9;
        #1 chk("alu_sub_zero", alu_res, 8'd0);
        alu_a = 8'd0; alu_b = 8'd0;

        // Extremes: 6 + 15, three extra WAIT cycles -> 1 + 4 = 5
        run_txn(8'd255, 8'd255, 8'd6, 8'd15, 3, 8'd21, 8'd5);
        // Hold with backpressure; in_valid and stray done must be ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                in_valid = 1'b1; a_in = 8'd8; b_in = 8'd9;
                k_done = 1'b1; alu_mode = 1'b1; alu_a = 8'd1; alu_b = 8'd1;
            end else begin
                in_valid = 1'b0;
                k_done = 1'b0; alu_mode = 1'b0; alu_a = 8'd0; alu_b = 8'd0;
            end
            if (i == 6 || i == 19) begin
                chk("hold_y", y, 8'd21);
                chk("hold_cycles", cycles, 8'd5);
                chk("hold_ready", {7'd0, in_ready}, 8'd0);
                chk("hold_k_a", k_a, 8'd255);
                chk("hold_valid", {7'd0, y_valid}, 8'd1);
            end
        end
        ack_result();
        run_txn(8'd8, 8'd9, 8'd2, 8'd3, 2, 8'd5, 8'd4);
        ack_result();

        run_txn(8'd0, 8'd0, 8'd0, 8'd0, 1, 8'd0, 8'd3);
        ack_result();

        // Reset two cycles after the start pulse
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'd100; b_in = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {7'd0, busy}, 8'd1);
        alu_mode = 1'b0; alu_a = 8'd3; alu_b = 8'd5;
        rst = 1'b0;
        #1 chk_reset_vals("rst_mid");
        chk("alu_in_reset", alu_res, 8'hFE);
        alu_a = 8'd0; alu_b = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(8'd64, 8'd81, 8'd4, 8'd9, 0, 8'd13, 8'd2);
        ack_result();

        // Done 300 cycles after start: latency 301 saturates to 255
        run_txn(8'd125, 8'd100, 8'd5, 8'd10, 299, 8'd15, 8'd255);
        ack_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbrt_sqrt_ctrl.md
# cbrt_sqrt_ctrl

Upstream controller and shared arithmetic unit for the cube-root/square-root sum kernel (y = cbrt(a) + sqrt(b)). It accepts operand pairs over a valid/ready handshake and registers them. It then pulses the kernel's start, serves the kernel's shared add/subtract bus combinationally, and captures the final sum on the kernel's done cycle. The result is held with a valid flag until the consumer acknowledges it, together with a measured latency count.

## Interface
- Parameters: none (all widths fixed at 8 bits).
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operand pair on a_bi/b_bi is valid.
- in_ready_o  out  1  controller can accept an operand pair (high only in IDLE).
- a_bi  in  8  operand for the cube root.
- b_bi  in  8  operand for the square root.
- k_a_bo  out  8  registered a to kernel; stable from START until the next accept.
- k_b_bo  out  8  registered b to kernel; same stability rule.
- k_start_o  out  1  one-cycle start pulse to kernel.
- k_done_i  in  1  kernel done; level signal.
- alu_mode_i  in  1  kernel ALU request mode; 1 = add, 0 = subtract.
- alu_a_i  in  8  kernel ALU operand A.
- alu_b_i  in  8  kernel ALU operand B.
- alu_res_o  out  8  ALU result back to kernel, combinational.
- y_bo  out  8  captured result.
- y_valid_o  out  1  y_bo is valid.
- y_ack_i  in  1  consumer takes the result.
- cycles_bo  out  8  cycles from start pulse to done, saturating at 255.
- busy_o  out  1  high in every state except IDLE.

## Operation
- ALU, purely combinational:
  - alu_res_o = alu_mode_i ? alu_a_i + alu_b_i : alu_a_i - alu_b_i.
  - Result is 8-bit modulo: wrap on overflow, two's-complement wrap on underflow, no carry out.
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i = 1: register a_bi → k_a_bo and b_bi → k_b_bo, clear the cycle counter, go to START.
- START:
  - k_start_o = 1 for exactly this cycle.
  - Counter is set to 1.
  - Go to WAIT unconditionally.
- WAIT:
  - Counter increments each cycle, saturating at 255.
  - On k_done_i = 1: capture alu_res_o into y_bo, copy the counter into cycles_bo, set y_valid_o, go to HOLD.
  - On the done cycle the kernel drives mode = add with the cube root and square root on the ALU bus, so the captured value is the final sum.
- HOLD:
  - y_valid_o = 1.
  - y_bo and cycles_bo are held.
  - On y_ack_i = 1: clear y_valid_o, go to IDLE.
- k_done_i is ignored outside WAIT.
- y_ack_i is ignored outside HOLD.
- in_valid_i is ignored outside IDLE, with no buffering.
- Operand widths:
  - cube root of an 8-bit value ≤ 6; square root ≤ 15.
  - Maximum sum is 21, so y_bo never wraps for legal kernel output.

## Timing
- Reset values: state IDLE; all of the following are 0: k_a_bo, k_b_bo, k_start_o, y_bo, y_valid_o, cycles_bo, busy_o. in_ready_o = 1.
- Accept takes place on the edge where IDLE and in_valid_i are both high. k_start_o is high during the following cycle.
- Capture takes place on the edge where WAIT and k_done_i are both high. y_valid_o rises the next cycle.
- Minimum latency from accept edge to y_valid_o: 3 cycles (START, WAIT with immediate done, HOLD).
- cycles_bo counts START plus each WAIT cycle up to and including the done cycle.
- ack in the same cycle that HOLD is entered: HOLD lasts one cycle. in_ready_o returns high the following cycle.
- No back-to-back overlap: a new accept is possible at the earliest one cycle after the ack edge.
- Reset asserted mid-operation (any state): immediate return to reset values. Any in-flight result is discarded.
- alu_res_o has zero latency: it follows the alu_* inputs in the same cycle in every state, including reset.

## Test plan
- Basic sum:
  - a=27, b=16 → y_bo=7 (3+4), y_valid_o high until ack.
  - k_start_o is high for exactly 1 cycle.
- Extremes:
  - a=255, b=255 → y_bo=21.
  - a=0, b=0 → y_bo=0.
  - cycles_bo is nonzero and matches the count of start-to-done cycles.
- Hold and backpressure:
  - Keep y_ack_i low for 20 cycles after valid → y_bo stable.
  - in_ready_o stays 0, and an in_valid_i pulse with a=8, b=9 is not accepted.
  - Then ack → IDLE.
  - The next accept of a=8, b=9 gives y_bo=5.
- ALU directed, with alu_* driven from the bench:
  - mode=1, 200+100 → 44.
  - mode=0, 3−5 → 0xFE.
  - mode=0, 9−9 → 0.
- Reset mid-WAIT:
  - Drop rst_i two cycles after the start pulse → all outputs at reset values asynchronously.
  - After release, in_ready_o=1 and a fresh transaction a=64, b=81 gives y_bo=13.
- Stub kernel that raises done 300 cycles after start → cycles_bo=255 (saturation), and the result is captured correctly.
